// File: rtl/branch_resolve_queue_if.sv
// Bus bundle for branch_resolve_queue: fetch push side, EX resolve side,
// registered redirect/BTB-update results and occupancy status.
// Optional BRQ_STATS_EN adds the resolve/mispredict statistics counters.
interface branch_resolve_queue_if #(
  parameter int PTR_BITS = 2
);
  logic                push_valid;
  logic [31:0]         push_pc;
  logic                push_pred_taken;
  logic [31:0]         push_pred_target;
  logic                push_ready;
  logic                resolve_valid;
  logic                resolve_taken;
  logic [31:0]         resolve_target;
  logic                mispredict;
  logic [31:0]         redirect_pc;
  logic                update_enable;
  logic [31:0]         update_pc;
  logic [31:0]         update_target;
  logic [PTR_BITS:0]   count;
  logic                empty;
  logic                full;
  logic                underflow;
`ifdef BRQ_STATS_EN
  logic [31:0]         stat_resolved;
  logic [31:0]         stat_mispredict;
`endif

  // Driver side: fetch and EX stages
  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output resolve_valid, resolve_taken, resolve_target,
    input  push_ready, mispredict, redirect_pc, update_enable,
    input  update_pc, update_target, count, empty, full, underflow
`ifdef BRQ_STATS_EN
    , input stat_resolved, input stat_mispredict
`endif
  );

  // Queue side
  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  resolve_valid, resolve_taken, resolve_target,
    output push_ready, mispredict, redirect_pc, update_enable,
    output update_pc, update_target, count, empty, full, underflow
`ifdef BRQ_STATS_EN
    , output stat_resolved, output stat_mispredict
`endif
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Fetch pushes predictions,
// EX pops the oldest on resolution; a mismatch flushes all younger entries
// and produces a registered redirect. Taken resolutions write the BTB.
// Optional macro BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic clock,
  input  logic reset,
  branch_resolve_queue_if.slave bus
);
  logic [31:0]         pc_mem     [DEPTH];
  logic                taken_mem  [DEPTH];
  logic [31:0]         target_mem [DEPTH];

  logic [PTR_BITS-1:0] head_reg;
  logic [PTR_BITS-1:0] tail_reg;
  logic [PTR_BITS:0]   count_reg;
  logic [PTR_BITS:0]   count_next;

  logic        full;
  logic        empty;
  logic        pop_en;
  logic        push_en;
  logic        mismatch;
  logic        flush;
  logic [31:0] head_pc;
  logic        head_taken;
  logic [31:0] head_target;

  assign full        = (count_reg == (PTR_BITS+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign head_pc     = pc_mem[head_reg];
  assign head_taken  = taken_mem[head_reg];
  assign head_target = target_mem[head_reg];

  // Not-taken/not-taken always matches; targets only matter when both are taken
  assign mismatch = (head_taken != bus.resolve_taken) ||
                    (head_taken && bus.resolve_taken && (head_target != bus.resolve_target));
  assign pop_en   = bus.resolve_valid && !empty;
  assign flush    = pop_en && mismatch;
  // A push alongside a flush is on the wrong path and is discarded
  assign push_en  = bus.push_valid && !full && !flush;

  assign bus.push_ready = !full;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count_reg;

  // Occupancy update: flush empties, otherwise net of push and pop
  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (push_en && !pop_en)
      count_next = count_reg + 1'b1;
    else if (pop_en && !push_en)
      count_next = count_reg - 1'b1;
  end

  // Entry storage, written at tail; contents need no reset
  always_ff @(posedge clock) begin
    if (push_en) begin
      pc_mem[tail_reg]     <= bus.push_pc;
      taken_mem[tail_reg]  <= bus.push_pred_taken;
      target_mem[tail_reg] <= bus.push_pred_target;
    end
  end

  // Pointers and count; on flush both pointers meet just past the popped entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (pop_en)
        head_reg <= head_reg + 1'b1;
      if (flush)
        tail_reg <= head_reg + 1'b1;
      else if (push_en)
        tail_reg <= tail_reg + 1'b1;
    end
  end

  // Registered resolution results, one cycle after the resolving edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mispredict    <= 1'b0;
      bus.redirect_pc   <= '0;
      bus.update_enable <= 1'b0;
      bus.update_pc     <= '0;
      bus.update_target <= '0;
      bus.underflow     <= 1'b0;
    end else begin
      bus.mispredict    <= flush;
      bus.update_enable <= pop_en && bus.resolve_taken;
      if (pop_en) begin
        bus.redirect_pc   <= bus.resolve_taken ? bus.resolve_target : head_pc + 32'd4;
        bus.update_pc     <= head_pc;
        bus.update_target <= bus.resolve_target;
      end
      if (bus.resolve_valid && empty)
        bus.underflow <= 1'b1;
    end
  end

`ifdef BRQ_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.stat_resolved   <= '0;
      bus.stat_mispredict <= '0;
    end else begin
      if (pop_en && (bus.stat_resolved != '1))
        bus.stat_resolved <= bus.stat_resolved + 32'd1;
      if (flush && (bus.stat_mispredict != '1))
        bus.stat_mispredict <= bus.stat_mispredict + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized bench for branch_resolve_queue with a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int PTR_BITS = 2;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  entry_t      q[$];
  logic        exp_mis;
  logic [31:0] exp_redirect;
  logic        exp_ue;
  logic [31:0] exp_upc;
  logic [31:0] exp_utgt;
  logic        exp_underflow;
  int          exp_resolved;
  int          exp_mispredicts;

  branch_resolve_queue_if #(.PTR_BITS(PTR_BITS)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_stats();
`ifdef BRQ_STATS_EN
    check("stat_resolved", bus.stat_resolved, 32'(exp_resolved));
    check("stat_mispredict", bus.stat_mispredict, 32'(exp_mispredicts));
`endif
  endtask

  task automatic model_clear();
    q.delete();
    exp_mis = 0; exp_ue = 0; exp_redirect = 0; exp_upc = 0; exp_utgt = 0;
    exp_underflow = 0; exp_resolved = 0; exp_mispredicts = 0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives
  task automatic do_reset();
    @(negedge clock);
    bus.push_valid = 0; bus.resolve_valid = 0;
    #2 reset = 1;
    #1;
    model_clear();
    check("rst_mispredict", 32'(bus.mispredict), 0);
    check("rst_update_en", 32'(bus.update_enable), 0);
    check("rst_update_pc", bus.update_pc, 0);
    check("rst_update_tgt", bus.update_target, 0);
    check("rst_redirect", bus.redirect_pc, 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_underflow", 32'(bus.underflow), 0);
    check_stats();
    @(negedge clock);
    reset = 0;
  endtask

  // One clock: drive, check combinational status, advance model, check results
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic rt,
                      input logic [31:0] rtg);
    int     pre_size;
    entry_t e;
    logic   mis;
    bus.push_valid = pv; bus.push_pc = ppc; bus.push_pred_taken = pt;
    bus.push_pred_target = ptg;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.resolve_target = rtg;
    #1;
    pre_size = q.size();
    check("push_ready", 32'(bus.push_ready), 32'(pre_size < DEPTH));
    check("full", 32'(bus.full), 32'(pre_size == DEPTH));
    check("count_pre", 32'(bus.count), 32'(pre_size));

    mis = 0; exp_ue = 0;
    if (rv && pre_size == 0) begin
      exp_underflow = 1;
    end else if (rv) begin
      e = q.pop_front();
      mis = (e.taken != rt) || (e.taken && rt && e.target != rtg);
      exp_redirect = rt ? rtg : e.pc + 32'd4;
      exp_ue = rt;
      exp_upc = e.pc;
      exp_utgt = rtg;
      exp_resolved++;
      if (mis) begin
        exp_mispredicts++;
        q.delete();
      end
    end
    exp_mis = mis;
    if (pv && pre_size < DEPTH && !mis) begin
      e.pc = ppc; e.taken = pt; e.target = ptg;
      q.push_back(e);
    end

    @(posedge clock);
    @(negedge clock);
    $display("txn push=%0b pc=%h res=%0b taken=%0b tgt=%h -> mis=%0b ue=%0b count=%0d",
             pv, ppc, rv, rt, rtg, bus.mispredict, bus.update_enable, bus.count);
    check("mispredict", 32'(bus.mispredict), 32'(exp_mis));
    check("update_enable", 32'(bus.update_enable), 32'(exp_ue));
    if (exp_mis) check("redirect_pc", bus.redirect_pc, exp_redirect);
    if (exp_ue) begin
      check("update_pc", bus.update_pc, exp_upc);
      check("update_target", bus.update_target, exp_utgt);
    end
    check("count", 32'(bus.count), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("underflow", 32'(bus.underflow), 32'(exp_underflow));
    check_stats();
  endtask

  initial begin
    logic        pv, pt, rv, rt;
    logic [31:0] ppc, ptg, rtg, r;
    total = 0; bad = 0;
    clock = 0; reset = 1;
    bus.push_valid = 0; bus.push_pc = 0; bus.push_pred_taken = 0;
    bus.push_pred_target = 0; bus.resolve_valid = 0; bus.resolve_taken = 0;
    bus.resolve_target = 0;
    model_clear();
    #3;
    check("init_count", 32'(bus.count), 0);
    check("init_mispredict", 32'(bus.mispredict), 0);
    @(negedge clock);
    reset = 0;

    // Correct taken prediction
    step(1, 32'h100, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h200);
    // Predicted not-taken, actually taken
    step(1, 32'h104, 0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h300);
    // Predicted taken, actually not-taken: redirect to pc+4, no BTB write
    step(1, 32'h108, 1, 32'h400, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    // Fill, overfill, drain in order
    for (int i = 0; i < 5; i++)
      step(1, 32'h500 + 32'(4 * i), 1, 32'h600 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 1, 32'h600 + 32'(i));
    // pc+4 wrap on a not-taken mispredict
    step(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h0);
    // Flush with a concurrent push, then resolve on empty
    for (int i = 0; i < 3; i++)
      step(1, 32'h700 + 32'(4 * i), 1, 32'h800, 0, 0, 0);
    step(1, 32'h7F0, 1, 32'h900, 1, 1, 32'h804);
    step(0, 0, 0, 0, 1, 1, 32'h0);

    do_reset();
    for (int n = 0; n < 800; n++) begin
      pv = ($urandom_range(0, 99) < 60);
      r = $urandom; ppc = r & 32'hFFFF_FFFC;
      pt = ($urandom_range(0, 99) < 60);
      ptg = 32'h1000 + 32'($urandom_range(0, 3) * 16);
      rv = ($urandom_range(0, 99) < 45);
      rt = $urandom_range(0, 1) == 1;
      rtg = 32'h1000 + 32'($urandom_range(0, 3) * 16);
      if (q.size() > 0 && $urandom_range(0, 99) < 70) begin
        rt = q[0].taken;
        if (q[0].taken) rtg = q[0].target;
      end
      step(pv, ppc, pt, ptg, rv, rt, rtg);
      if (n == 400) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
